// File: rtl/sr_cmd_gen.sv
// Command stage for an SR flop: sync + debounce two raw requests, arbitrate, emit exclusive S/R pulses.
// Request rise -> S/R after DEB_CYCLES+3 edges; optional tie counter enabled by SR_CONFLICT_CNT_EN.
module sr_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 1,
    parameter int GAP_LEN    = 1,
    parameter int SET_PRIO   = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_req,
    input  logic             clr_req,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Channel index 0 = set, 1 = clear throughout.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    armed;
    logic [1:0]    prime;
    logic [1:0]    rise;
    logic [1:0]    pend;
    logic [1:0]    pick;
    logic [DW-1:0] deb_cnt [2];
    logic [TW-1:0] tcnt;
    logic          issue;
    state_t        state;

    assign raw = {clr_req, set_req};

    // A channel only arms once its synchronised level has been seen low after reset,
    // so a request still held across reset cannot masquerade as a fresh rise.
    assign rise = deb & ~deb_d & armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            deb_d      <= '0;
            armed      <= '0;
            prime      <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            prime <= {prime[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (prime[1] && !sync2[i]) begin
                    armed[i] <= 1'b1;
                end
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pick = pend;
        if (pend == 2'b11) begin
            pick = (SET_PRIO != 0) ? 2'b01 : 2'b10;
        end
    end

    // The last GAP clock doubles as the IDLE decision point so back-to-back
    // commands are separated by exactly GAP_LEN low clocks.
    assign issue = (|pend) &&
                   ((state == IDLE) || ((state == GAP) && (tcnt == GAP_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            S     <= 1'b0;
            R     <= 1'b0;
            pend  <= '0;
        end else begin
            pend <= (pend & ~(issue ? pick : 2'b00)) | rise;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (issue) begin
                        state <= DRIVE;
                        S     <= pick[0];
                        R     <= pick[1];
                    end
                end
                DRIVE: begin
                    if (tcnt == PULSE_LAST) begin
                        state <= GAP;
                        S     <= 1'b0;
                        R     <= 1'b0;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (tcnt == GAP_LAST) begin
                        tcnt <= '0;
                        if (issue) begin
                            state <= DRIVE;
                            S     <= pick[0];
                            R     <= pick[1];
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tcnt  <= '0;
                    S     <= 1'b0;
                    R     <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) || (|pend);

`ifdef SR_CONFLICT_CNT_EN
    logic tie;
    assign tie = &pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (issue && tie && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

    a_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(S && R));
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
                                   (state == IDLE) |-> (!S && !R));

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: reset, latency, debounce, tie-break, back-to-back and random invariants.
module tb_sr_cmd_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       s1, r1, busy1;
    logic [7:0] cc1;
    logic       s2, r2, busy2;
    logic [7:0] cc2;
    int         total = 0;
    int         bad = 0;

`ifdef SR_CONFLICT_CNT_EN
    localparam logic [7:0] EXP_CONFLICT = 8'd1;
`else
    localparam logic [7:0] EXP_CONFLICT = 8'd0;
`endif

    always #5 clk = ~clk;

    sr_cmd_gen dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .S(s1), .R(r1), .busy(busy1), .conflict_cnt(cc1)
    );

    sr_cmd_gen #(.PULSE_LEN(2), .GAP_LEN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .S(s2), .R(r2), .busy(busy2), .conflict_cnt(cc2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns just after a rising edge, so the next edge is "edge 0".
    task automatic arm_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        #2;
        total++; if (s1 !== 1'b0)    begin bad++; $display("FAIL reset_S got=%b want=0", s1); end
        total++; if (r1 !== 1'b0)    begin bad++; $display("FAIL reset_R got=%b want=0", r1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
        total++; if (cc1 !== 8'd0)   begin bad++; $display("FAIL reset_cnt got=%0d want=0", cc1); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        arm_edge();
        set_req = 1'b1;
        n = 0;
        while (s1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++; if (s1 !== 1'b1) begin bad++; $display("FAIL reset_pulse_timeout got=%b want=1", s1); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (s1 !== 1'b0)    begin bad++; $display("FAIL reset_async_S got=%b want=0", s1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_async_busy got=%b want=0", busy1); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (s1 !== 1'b0 || r1 !== 1'b0) begin
                bad++; $display("FAIL reset_no_reissue cyc=%0d got S=%b R=%b want 0 0", i, s1, r1);
            end
        end
        set_req = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_set();
        logic exp_s, exp_b;
        arm_edge();
        set_req = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            exp_s = (e == 7);
            exp_b = (e >= 6 && e <= 8);
            total++; if (s1 !== exp_s) begin bad++; $display("FAIL set_S edge=%0d got=%b want=%b", e, s1, exp_s); end
            total++; if (r1 !== 1'b0)  begin bad++; $display("FAIL set_R edge=%0d got=%b want=0", e, r1); end
            total++; if (busy1 !== exp_b) begin bad++; $display("FAIL set_busy edge=%0d got=%b want=%b", e, busy1, exp_b); end
        end
        set_req = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        int rcnt;
        arm_edge();
        clr_req = 1'b1;
        repeat (3) arm_edge();
        clr_req = 1'b0;
        arm_edge();
        clr_req = 1'b1;
        repeat (3) arm_edge();
        clr_req = 1'b0;
        rcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (r1 === 1'b1) rcnt++;
        end
        total++; if (rcnt != 0) begin bad++; $display("FAIL bounce_glitch got=%0d pulses want=0", rcnt); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL bounce_busy got=%b want=0", busy1); end
        arm_edge();
        clr_req = 1'b1;
        rcnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 9) clr_req = 1'b0;
            if (r1 === 1'b1) rcnt++;
            total++; if (s1 !== 1'b0) begin bad++; $display("FAIL bounce_S cyc=%0d got=%b want=0", i, s1); end
        end
        total++; if (rcnt != 1) begin bad++; $display("FAIL bounce_clean got=%0d R clocks want=1", rcnt); end
        repeat (5) tick();
    endtask

    task automatic test_tie();
        logic exp_s, exp_r;
        arm_edge();
        set_req = 1'b1;
        clr_req = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            exp_s = (e == 9);
            exp_r = (e == 7);
            total++; if (s1 !== exp_s) begin bad++; $display("FAIL tie_S edge=%0d got=%b want=%b", e, s1, exp_s); end
            total++; if (r1 !== exp_r) begin bad++; $display("FAIL tie_R edge=%0d got=%b want=%b", e, r1, exp_r); end
            if (e == 7) begin
                total++;
                if (cc1 !== EXP_CONFLICT) begin bad++; $display("FAIL tie_cnt got=%0d want=%0d", cc1, EXP_CONFLICT); end
            end
        end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL tie_busy got=%b want=0", busy1); end
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        logic exp_s, exp_r;
        arm_edge();
        set_req = 1'b1;
        arm_edge();
        clr_req = 1'b1;
        for (int e = 1; e < 16; e++) begin
            tick();
            exp_s = (e == 7 || e == 8);
            exp_r = (e == 11 || e == 12);
            total++; if (s2 !== exp_s) begin bad++; $display("FAIL b2b_S edge=%0d got=%b want=%b", e, s2, exp_s); end
            total++; if (r2 !== exp_r) begin bad++; $display("FAIL b2b_R edge=%0d got=%b want=%b", e, r2, exp_r); end
        end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", busy2); end
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_random();
        logic any1, prev1, seen1, any2, prev2, seen2;
        int   hl1, ll1, hl2, ll2;
        prev1 = 1'b0; seen1 = 1'b0; hl1 = 0; ll1 = 0;
        prev2 = 1'b0; seen2 = 1'b0; hl2 = 0; ll2 = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(5) == 0) set_req = ~set_req;
            if ($urandom_range(5) == 0) clr_req = ~clr_req;
            @(negedge clk);
            total++; if (s1 && r1) begin bad++; $display("FAIL rand_excl1 cyc=%0d got S=1 R=1 want not both", c); end
            total++; if (s2 && r2) begin bad++; $display("FAIL rand_excl2 cyc=%0d got S=1 R=1 want not both", c); end
            any1 = s1 | r1;
            if (any1) begin
                if (!prev1 && seen1) begin
                    total++; if (ll1 < 1) begin bad++; $display("FAIL rand_gap1 cyc=%0d got=%0d want>=1", c, ll1); end
                end
                hl1 = prev1 ? hl1 + 1 : 1;
            end else begin
                if (prev1) begin
                    total++; if (hl1 != 1) begin bad++; $display("FAIL rand_width1 cyc=%0d got=%0d want=1", c, hl1); end
                    seen1 = 1'b1;
                end
                ll1 = prev1 ? 1 : ll1 + 1;
            end
            prev1 = any1;
            any2 = s2 | r2;
            if (any2) begin
                if (!prev2 && seen2) begin
                    total++; if (ll2 < 2) begin bad++; $display("FAIL rand_gap2 cyc=%0d got=%0d want>=2", c, ll2); end
                end
                hl2 = prev2 ? hl2 + 1 : 1;
            end else begin
                if (prev2) begin
                    total++; if (hl2 != 2) begin bad++; $display("FAIL rand_width2 cyc=%0d got=%0d want=2", c, hl2); end
                    seen2 = 1'b1;
                end
                ll2 = prev2 ? 1 : ll2 + 1;
            end
            prev2 = any2;
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (20) tick();
        total++; if (!seen1 || !seen2) begin bad++; $display("FAIL rand_activity got seen=%b%b want 11", seen1, seen2); end
    endtask

    initial begin
        test_reset();
        test_set();
        test_bounce();
        test_tie();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
